// File: rtl/pll_freq_meter.sv
// Multi-channel PLL frequency meter: synchronises asynchronous channel signals into clk and
// counts their rising edges, either free-running (wrapping) or over a gated window with saturation.
module pll_freq_meter #(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = 32,
  parameter int GATE_W      = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    i_rst,
  input  logic                    i_enable,
  input  logic                    i_mode,
  input  logic                    i_start,
  input  logic [GATE_W-1:0]       i_gate_cycles,
  input  logic [NUM_CH-1:0]       i_chan_sig,
  output logic [NUM_CH*CNT_W-1:0] o_count,
  output logic                    o_valid,
  output logic                    o_busy,
  output logic [NUM_CH-1:0]       o_sat
);

  typedef enum logic [1:0] {
    IDLE,
    GATE,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [NUM_CH-1:0][SYNC_STAGES-1:0] sync_q;
  logic [NUM_CH-1:0]                  sync_out;
  logic [NUM_CH-1:0]                  dly_q;
  logic [NUM_CH-1:0]                  rise;

  logic [NUM_CH-1:0][CNT_W-1:0]       live_q;
  logic [NUM_CH-1:0]                  sat_q;
  logic [GATE_W-1:0]                  timer_q;

  // Synchroniser chain plus one delay flop per channel; cleared so nothing is pending after reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      sync_q <= '0;
      dly_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], i_chan_sig[i]};
      end
      dly_q <= sync_out;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      sync_out[i] = sync_q[i][SYNC_STAGES-1];
    end
    rise = sync_out & ~dly_q;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (i_enable && i_mode && i_start && (i_gate_cycles != '0)) begin
          state_d = GATE;
        end
      end
      GATE: begin
        if (!i_enable) begin
          state_d = IDLE;
        end else if (timer_q == GATE_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      live_q  <= '0;
      sat_q   <= '0;
      o_count <= '0;
      o_sat   <= '0;
      o_valid <= 1'b0;
      o_busy  <= 1'b0;
    end else begin
      state_q <= state_d;
      o_valid <= 1'b0;
      o_busy  <= (state_d == GATE);
      case (state_q)
        IDLE: begin
          if (state_d == GATE) begin
            live_q  <= '0;
            sat_q   <= '0;
            timer_q <= i_gate_cycles;
          end else if (!i_mode) begin
            // Legacy free-run: wrap-around counting, result mirrored one cycle later.
            if (i_enable) begin
              for (int i = 0; i < NUM_CH; i++) begin
                live_q[i] <= live_q[i] + CNT_W'(rise[i]);
              end
            end
            o_count <= live_q;
            o_sat   <= '0;
          end
        end
        GATE: begin
          if (i_enable) begin
            timer_q <= timer_q - GATE_W'(1);
            for (int i = 0; i < NUM_CH; i++) begin
              if (rise[i]) begin
                if (live_q[i] == '1) begin
                  sat_q[i] <= 1'b1;
                end else begin
                  live_q[i] <= live_q[i] + CNT_W'(1);
                end
              end
            end
          end
        end
        DONE: begin
          o_count <= live_q;
          o_sat   <= sat_q;
          o_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pll_freq_meter.sv
// Randomised scoreboard bench for pll_freq_meter: records every driven channel sample and
// derives expected counts by counting recorded rising edges inside each measurement window.
module tb_pll_freq_meter;

  localparam int NUM_CH = 2;
  localparam int CNT_W  = 8;
  localparam int GATE_W = 12;
  localparam int S      = 2;
  localparam int MAXC   = 20000;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic                    clk = 1'b0;
  logic                    i_rst;
  logic                    i_enable;
  logic                    i_mode;
  logic                    i_start;
  logic [GATE_W-1:0]       i_gate_cycles;
  logic [NUM_CH-1:0]       i_chan_sig;
  logic [NUM_CH*CNT_W-1:0] o_count;
  logic                    o_valid;
  logic                    o_busy;
  logic [NUM_CH-1:0]       o_sat;

  pll_freq_meter #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .GATE_W(GATE_W), .SYNC_STAGES(S)
  ) dut (
    .clk(clk), .i_rst(i_rst), .i_enable(i_enable), .i_mode(i_mode), .i_start(i_start),
    .i_gate_cycles(i_gate_cycles), .i_chan_sig(i_chan_sig), .o_count(o_count),
    .o_valid(o_valid), .o_busy(o_busy), .o_sat(o_sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    int p0;
    int n;
  } win_t;

  win_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  bit [NUM_CH-1:0] hist [MAXC];
  int   half [NUM_CH];
  int   cntdn [NUM_CH];
  bit   run_ch = 1'b0;
  int   last_cnt [NUM_CH];
  bit   last_sat [NUM_CH];
  int   busy_len = 0;
  int   last_busy = 0;
  bit   busy_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int rises(input int ch, input int lo, input int hi);
    int n = 0;
    for (int k = lo - S; k <= hi - S; k++) begin
      if (k >= 1 && k < MAXC && hist[k][ch] && !hist[k-1][ch]) n++;
    end
    return n;
  endfunction

  function automatic int cnt_of(input int ch);
    return int'(o_count[ch*CNT_W +: CNT_W]);
  endfunction

  // Channel generators: square waves with half-periods >= 2 clk, recorded per sampling edge.
  always @(negedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (run_ch) begin
        if (cntdn[i] <= 1) begin
          i_chan_sig[i] = ~i_chan_sig[i];
          cntdn[i] = half[i];
        end else begin
          cntdn[i] = cntdn[i] - 1;
        end
      end
    end
    if (cyc + 1 < MAXC) hist[cyc+1] = i_chan_sig;
  end

  // Monitor: tracks busy length and checks each o_valid against the oldest pending window.
  always @(negedge clk) begin
    win_t w;
    int   c;
    int   e;
    if (o_busy) busy_len++;
    else if (busy_prev) begin
      last_busy = busy_len;
      busy_len = 0;
    end
    busy_prev = o_busy;
    if (o_valid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        w = sb_q.pop_front();
        check("valid_timing", cyc, w.p0 + w.n + 1);
        check("busy_length", last_busy, w.n);
        for (int ch = 0; ch < NUM_CH; ch++) begin
          c = rises(ch, w.p0 + 1, w.p0 + w.n);
          e = (c > CMAX) ? CMAX : c;
          check($sformatf("gated_count_ch%0d_n%0d", ch, w.n), cnt_of(ch), e);
          check($sformatf("gated_sat_ch%0d_n%0d", ch, w.n), o_sat[ch], (c > CMAX) ? 1 : 0);
          last_cnt[ch] = e;
          last_sat[ch] = (c > CMAX);
        end
      end
    end
  end

  task automatic start_run(input int n, input bit expect_result);
    @(negedge clk);
    i_mode = 1'b1;
    i_enable = 1'b1;
    i_gate_cycles = GATE_W'(n);
    i_start = 1'b1;
    if (expect_result) sb_q.push_back('{p0: cyc + 1, n: n});
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int  k = 0;
    bit  ok = 1'b0;
    while (k < budget && !ok) begin
      @(negedge clk);
      k++;
      ok = !o_busy && (sb_q.size() == 0);
    end
    check("idle_reached", ok, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_hold(input string tag);
    for (int ch = 0; ch < NUM_CH; ch++) begin
      check($sformatf("%s_count_ch%0d", tag, ch), cnt_of(ch), last_cnt[ch]);
      check($sformatf("%s_sat_ch%0d", tag, ch), o_sat[ch], last_sat[ch]);
    end
    check({tag, "_busy"}, o_busy, 0);
  endtask

  initial begin
    int fr_start;
    int fr_end;
    i_rst = 1'b1; i_enable = 1'b0; i_mode = 1'b0; i_start = 1'b0;
    i_gate_cycles = '0; i_chan_sig = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      half[i] = 2; cntdn[i] = 2; last_cnt[i] = 0; last_sat[i] = 0;
    end
    repeat (5) @(negedge clk);
    check("reset_count", o_count, 0);
    check("reset_sat", o_sat, 0);
    check("reset_valid", o_valid, 0);
    check("reset_busy", o_busy, 0);
    i_rst = 1'b0;

    // Free-run: periods 4 and 8 clk, wrap at 256.
    half[0] = 2; half[1] = 4;
    run_ch = 1'b1;
    i_mode = 1'b0; i_enable = 1'b1;
    fr_start = cyc + 1;
    repeat (400) @(negedge clk);
    for (int ch = 0; ch < NUM_CH; ch++)
      check($sformatf("free400_ch%0d", ch), cnt_of(ch), rises(ch, fr_start, cyc - 1) % 256);
    repeat (700) @(negedge clk);
    for (int ch = 0; ch < NUM_CH; ch++)
      check($sformatf("free1100_ch%0d", ch), cnt_of(ch), rises(ch, fr_start, cyc - 1) % 256);
    i_enable = 1'b0;
    fr_end = cyc;
    repeat (50) @(negedge clk);
    for (int ch = 0; ch < NUM_CH; ch++)
      check($sformatf("frozen_ch%0d", ch), cnt_of(ch), rises(ch, fr_start, fr_end) % 256);
    check("free_sat", o_sat, 0);

    // Gated 1000 with ignored start/mode/length changes mid-window.
    half[0] = 2; half[1] = 5;
    repeat (20) @(negedge clk);
    start_run(1000, 1'b1);
    repeat (100) @(negedge clk);
    i_mode = 1'b0; i_gate_cycles = 12'd5; i_start = 1'b1;
    repeat (50) @(negedge clk);
    i_start = 1'b0; i_mode = 1'b1;
    wait_idle(1200);

    // Saturation: 500 edges on ch0 into an 8-bit counter.
    start_run(2000, 1'b1);
    wait_idle(2200);

    // Zero-length window is ignored.
    start_run(0, 1'b0);
    repeat (10) @(negedge clk);
    check_hold("zero_gate");

    // One-cycle window.
    start_run(1, 1'b1);
    wait_idle(20);

    // Start held through GATE and DONE: rerun only once IDLE samples it again.
    @(negedge clk);
    i_gate_cycles = 12'd3; i_start = 1'b1;
    sb_q.push_back('{p0: cyc + 1, n: 3});
    sb_q.push_back('{p0: cyc + 6, n: 3});
    repeat (6) @(negedge clk);
    i_start = 1'b0;
    wait_idle(30);

    // Randomised windows and channel rates.
    for (int r = 0; r < 6; r++) begin
      half[0] = $urandom_range(8, 2);
      half[1] = $urandom_range(8, 2);
      repeat ($urandom_range(20, 10)) @(negedge clk);
      start_run($urandom_range(400, 1), 1'b1);
      wait_idle(500);
    end

    // Abort by dropping enable at window cycle 300.
    start_run(600, 1'b0);
    repeat (299) @(negedge clk);
    i_enable = 1'b0;
    repeat (10) @(negedge clk);
    check_hold("abort");
    i_enable = 1'b1;

    // Synchronous reset mid-window.
    start_run(500, 1'b0);
    repeat (100) @(negedge clk);
    i_rst = 1'b1;
    @(negedge clk);
    check("midreset_count", o_count, 0);
    check("midreset_sat", o_sat, 0);
    check("midreset_busy", o_busy, 0);
    check("midreset_valid", o_valid, 0);
    i_rst = 1'b0;
    for (int ch = 0; ch < NUM_CH; ch++) begin last_cnt[ch] = 0; last_sat[ch] = 0; end
    repeat (30) @(negedge clk);
    check_hold("post_reset_idle");
    start_run(150, 1'b1);
    wait_idle(200);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #(MAXC * 10);
    $display("FAIL watchdog: simulation exceeded %0d cycles", MAXC);
    $fatal(1, "watchdog");
  end

endmodule
